// File: rtl/tinychip_pkg.sv
// Shared TinyChip ISA definitions for the instruction encoder/loader.
//   INSTR_W / OPC_W / REG_W : instruction and field widths
//   instr_fields_t          : decoded field bundle, MSB-first in ISA order
//   encode_instr()          : packs a field bundle into a 9-bit instruction word
//   load_state_t            : loader session states
package tinychip_pkg;

    localparam int INSTR_W = 9;
    localparam int OPC_W   = 3;
    localparam int REG_W   = 2;

    typedef struct packed {
        logic             bit_type;
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] reg_dest;
        logic [REG_W-1:0] reg_op;
        logic             funct;
    } instr_fields_t;

    // Pure concatenation; no field is range-checked.
    function automatic logic [INSTR_W-1:0] encode_instr(input instr_fields_t f);
        return {f.bit_type, f.opcode, f.reg_dest, f.reg_op, f.funct};
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } load_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO buffering encoded instructions between the field
// interface and the instruction-memory write port.
//   clk, reset : posedge clock, synchronous active-high reset (empties FIFO)
//   push, din  : write din when push and not full
//   pop        : discard head when pop and not empty
//   full/empty : occupancy flags
//   head       : oldest entry (registered storage, no comb path from inputs)
module instr_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Field-level instruction encoder and sequential instruction-memory loader.
// Accepts decoded field bundles over valid/ready, encodes them to 9-bit
// instructions, buffers them in a FIFO and drains them into the instruction
// memory at incrementing (wrapping) addresses.
//   clk, reset          : posedge clock, synchronous active-high reset
//   start, base_addr    : open a session at base_addr (IDLE only)
//   in_valid/in_ready   : field bundle handshake
//   bit_type..funct     : instruction fields, last marks final bundle
//   im_ready            : memory accepts the presented write
//   im_we/addr/wdata    : instruction-memory write port (register-driven)
//   busy, done          : session active / one-cycle completion pulse
//   wr_count            : words written in the current or last session
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; no accepts, no writes
// LOAD  | accepting bundles and draining the FIFO
// FLUSH | last bundle accepted; draining the remaining FIFO entries
// DONE  | session complete; done asserted for this single cycle
module instr_encoder_loader
    import tinychip_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              bit_type,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [REG_W-1:0]  reg_dest,
    input  logic [REG_W-1:0]  reg_op,
    input  logic              funct,
    input  logic              last,
    input  logic              im_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count
);

    load_state_t        state;
    logic [ADDR_W-1:0]  addr;
    logic               fifo_full;
    logic               fifo_empty;
    logic [INSTR_W-1:0] fifo_head;
    logic               draining;
    logic               accept;
    logic               wr_done;
    instr_fields_t      fields;

    assign fields = '{bit_type: bit_type, opcode: opcode, reg_dest: reg_dest,
                      reg_op: reg_op, funct: funct};

    // All handshake/output terms come from registered state only.
    assign draining = (state == LOAD) || (state == FLUSH);
    assign in_ready = (state == LOAD) && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign im_we    = draining && !fifo_empty;
    assign wr_done  = im_we && im_ready;
    assign im_addr  = addr;
    assign im_wdata = im_we ? fifo_head : '0;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (encode_instr(fields)),
        .pop   (wr_done),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            wr_count <= '0;
        end else begin
            if (wr_done) begin
                addr <= addr + ADDR_W'(1);
                if (wr_count != '1) begin
                    wr_count <= wr_count + (ADDR_W+1)'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        addr     <= base_addr;
                        wr_count <= '0;
                    end
                end
                LOAD: begin
                    if (accept && last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fifo_empty) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
